// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding,
// default game parameters and the BCD digit type used for the score.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } pong_state_e;

    localparam int DEFAULT_LIVES       = 3;
    localparam int DEFAULT_WAIT_FRAMES = 120;

    typedef logic [3:0] bcd_digit_t;

    // Single BCD digit step, 9 rolls over to 0.
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear and increment-enable,
// wrapping 99 -> 00. Holds the game score.
import pong_pkg::*;

module bcd_counter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t d1,
    output bcd_digit_t d0
);

    // Clear wins over increment; tens only advance when ones roll over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (clr) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (inc) begin
            d0 <= bcd_inc(d0);
            if (d0 == 4'd9)
                d1 <= bcd_inc(d1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: sequences IDLE/PLAY/NEWBALL/OVER, keeps score and
// lives, and paces the pauses between balls with a frame-tick timer.
import pong_pkg::*;

module pong_game_ctrl #(
    parameter int LIVES       = DEFAULT_LIVES,
    parameter int WAIT_FRAMES = DEFAULT_WAIT_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       hit,
    input  logic       miss,
    output logic       graph_still,
    output logic       ball_reset,
    output logic       game_over,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] lives,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_PLAY    = PLAY;
    localparam logic [1:0] ST_NEWBALL = NEWBALL;
    localparam logic [1:0] ST_OVER    = OVER;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] WAIT_INIT  = 8'(WAIT_FRAMES);

    logic [1:0] state_reg, state_next;
    logic [1:0] lives_reg, lives_next;
    logic [7:0] timer_reg, timer_next;
    logic       btn_prev;
    logic       start_edge;
    logic       ball_reset_next;
    logic       score_clr;
    logic       score_inc;

    assign start_edge = btn_start & ~btn_prev;

    // Next-state logic; a miss outranks a coincident hit, and a timer load
    // only happens in PLAY so it can never collide with a decrement.
    always_comb begin
        state_next      = state_reg;
        lives_next      = lives_reg;
        timer_next      = timer_reg;
        ball_reset_next = 1'b0;
        score_clr       = 1'b0;
        score_inc       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next      = ST_PLAY;
                    lives_next      = LIVES_INIT;
                    score_clr       = 1'b1;
                    ball_reset_next = 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    timer_next = WAIT_INIT;
                    if (lives_reg > 2'd1) begin
                        lives_next = lives_reg - 2'd1;
                        state_next = ST_NEWBALL;
                    end else begin
                        lives_next = 2'd0;
                        state_next = ST_OVER;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (timer_reg == 8'd0) begin
                    state_next      = ST_PLAY;
                    ball_reset_next = 1'b1;
                end else if (frame_tick) begin
                    timer_next = timer_reg - 8'd1;
                end
            end
            ST_OVER: begin
                if (timer_reg == 8'd0)
                    state_next = ST_IDLE;
                else if (frame_tick)
                    timer_next = timer_reg - 8'd1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            lives_reg  <= LIVES_INIT;
            timer_reg  <= 8'd0;
            btn_prev   <= 1'b0;
            ball_reset <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lives_reg  <= lives_next;
            timer_reg  <= timer_next;
            btn_prev   <= btn_start;
            ball_reset <= ball_reset_next;
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .d1    (score_d1),
        .d0    (score_d0)
    );

    assign state       = state_reg;
    assign lives       = lives_reg;
    assign graph_still = (state_reg != ST_PLAY);
    assign game_over   = (state_reg == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a game-rule model checked every cycle plus
// directed scenarios with literal expectations.
module tb_pong_game_ctrl;

    localparam int M_LIVES = 3;
    localparam int M_WAIT  = 120;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       graph_still, ball_reset, game_over;
    logic [3:0] score_d1, score_d0;
    logic [1:0] lives, state;

    int assertions = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int m_state = 0;
    int m_score = 0;
    int m_lives = M_LIVES;
    int m_timer = 0;
    bit m_btn_prev = 1'b0;
    bit m_ball_reset = 1'b0;

    pong_game_ctrl #(.LIVES(M_LIVES), .WAIT_FRAMES(M_WAIT)) dut (
        .clk         (clk),
        .reset       (reset_n),
        .frame_tick  (frame_tick),
        .btn_start   (btn_start),
        .hit         (hit),
        .miss        (miss),
        .graph_still (graph_still),
        .ball_reset  (ball_reset),
        .game_over   (game_over),
        .score_d1    (score_d1),
        .score_d0    (score_d0),
        .lives       (lives),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit h, input bit m, input bit t, input bit b);
        @(negedge clk);
        hit        = h;
        miss       = m;
        frame_tick = t;
        btn_start  = b;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, btn_start);
    endtask

    task automatic pulseHit(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, 0, 0, btn_start);
            applyStimulus(0, 0, 0, btn_start);
        end
    endtask

    task automatic pulseTick(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 1, btn_start);
            applyStimulus(0, 0, 0, btn_start);
        end
    endtask

    // Game-rule model: integer score, lives and pause counter per the rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_score = 0; m_lives = M_LIVES;
            m_timer = 0; m_btn_prev = 0; m_ball_reset = 0;
        end else begin
            bit start_seen;
            start_seen   = btn_start && !m_btn_prev;
            m_btn_prev   = btn_start;
            m_ball_reset = 0;
            if (m_state == 0) begin
                if (start_seen) begin
                    m_score = 0; m_lives = M_LIVES; m_state = 1; m_ball_reset = 1;
                end
            end else if (m_state == 1) begin
                if (miss) begin
                    m_lives = m_lives - 1;
                    m_timer = M_WAIT;
                    m_state = (m_lives == 0) ? 3 : 2;
                end else if (hit) begin
                    m_score = (m_score + 1) % 100;
                end
            end else begin
                if (m_timer == 0) begin
                    m_ball_reset = (m_state == 2);
                    m_state      = (m_state == 2) ? 1 : 0;
                end else if (frame_tick) begin
                    m_timer = m_timer - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model state", int'(state), m_state);
            checkOutput("model score_d1", int'(score_d1), m_score / 10);
            checkOutput("model score_d0", int'(score_d0), m_score % 10);
            checkOutput("model lives", int'(lives), m_lives);
            checkOutput("model ball_reset", int'(ball_reset), int'(m_ball_reset));
            checkOutput("model graph_still", int'(graph_still), int'(m_state != 1));
            checkOutput("model game_over", int'(game_over), int'(m_state == 3));
        end
    end

    initial begin
        idleCycles(3);
        checkOutput("reset state", int'(state), 0);
        checkOutput("reset graph_still", int'(graph_still), 1);
        checkOutput("reset lives", int'(lives), 3);
        checkOutput("reset game_over", int'(game_over), 0);
        check_en = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        idleCycles(3);

        // Start with the button held for 1000 cycles: one game start only.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("start state", int'(state), 1);
        checkOutput("start ball_reset", int'(ball_reset), 1);
        checkOutput("start graph_still", int'(graph_still), 0);
        checkOutput("start score", int'({score_d1, score_d0}), 8'h00);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ball_reset one cycle", int'(ball_reset), 0);
        idleCycles(997);
        applyStimulus(0, 0, 0, 0);
        idleCycles(2);
        checkOutput("held button state", int'(state), 1);

        // Second start press during PLAY is ignored.
        applyStimulus(0, 0, 0, 1);
        idleCycles(2);
        applyStimulus(0, 0, 0, 0);
        checkOutput("restart ignored ball_reset", int'(ball_reset), 0);

        pulseHit(10);
        checkOutput("10 hits tens", int'(score_d1), 1);
        checkOutput("10 hits ones", int'(score_d0), 0);
        pulseHit(90);
        checkOutput("100 hits wrap", int'({score_d1, score_d0}), 8'h00);

        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("miss -> NEWBALL", int'(state), 2);
        checkOutput("miss lives", int'(lives), 2);
        pulseHit(2);
        pulseTick(119);
        checkOutput("119 ticks still NEWBALL", int'(state), 2);
        pulseTick(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("120 ticks -> PLAY", int'(state), 1);
        checkOutput("serve ball_reset", int'(ball_reset), 1);

        pulseHit(5);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        pulseTick(120);
        idleCycles(2);
        checkOutput("second serve lives", int'(lives), 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("hit+miss score", int'({score_d1, score_d0}), 8'h05);
        checkOutput("hit+miss lives", int'(lives), 0);
        checkOutput("hit+miss OVER", int'(state), 3);
        checkOutput("hit+miss game_over", int'(game_over), 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        pulseTick(120);
        applyStimulus(0, 0, 0, 0);
        checkOutput("OVER -> IDLE", int'(state), 0);
        checkOutput("score held in IDLE", int'({score_d1, score_d0}), 8'h05);

        // New game, then asynchronous reset with the pause timer at 50.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("new game lives", int'(lives), 3);
        pulseHit(7);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        pulseTick(70);
        checkOutput("pre-reset state", int'(state), 2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset state", int'(state), 0);
        checkOutput("async reset score", int'({score_d1, score_d0}), 8'h00);
        checkOutput("async reset lives", int'(lives), 3);
        checkOutput("async reset graph_still", int'(graph_still), 1);
        checkOutput("async reset ball_reset", int'(ball_reset), 0);
        checkOutput("async reset game_over", int'(game_over), 0);
        idleCycles(2);
        @(negedge clk) reset_n = 1'b1;
        idleCycles(2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("post-reset start", int'(state), 1);
        idleCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, balls per game (legal range 1-3).
REQ-002 Parameter WAIT_FRAMES, default 120, frames held between balls and after game over (2 s at 60 Hz; legal range 1-255).
REQ-003 clk  input  1  system clock, the same clock that feeds the VGA sync and pixel generator.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 frame_tick  input  1  one-cycle pulse per video frame, from the sync block at start of vertical blank.
REQ-006 btn_start  input  1  start button level, already synchronized and debounced.
REQ-007 hit  input  1  one-cycle pulse: the ball struck the paddle (from the pixel generator).
REQ-008 miss  input  1  one-cycle pulse: the ball passed the paddle.
REQ-009 graph_still  output  1  1 = the pixel generator freezes ball and paddle motion.
REQ-010 ball_reset  output  1  one-cycle pulse: the ball returns to its serve position.
REQ-011 game_over  output  1  1 while in state OVER.
REQ-012 score_d1, score_d0  output  4 each  two-digit BCD score (tens, ones).
REQ-013 lives  output  2  balls remaining.
REQ-014 state  output  2  current state encoding, used for text overlay selection.

Function
REQ-015 The block SHALL implement a four-state FSM with states IDLE=0, PLAY=1, NEWBALL=2 and OVER=3.
REQ-016 start_edge SHALL be a rising edge of btn_start, detected with one internal register; a held button gives a single edge.
REQ-017 IDLE: graph_still=1; on start_edge -> PLAY, clear score to 00, load lives=LIVES, pulse ball_reset.
REQ-018 PLAY: graph_still=0; on hit with no miss in the same cycle, score SHALL increment by 1 in BCD (x9 -> (x+1)0; 99 -> 00).
REQ-019 PLAY, miss with lives>1: lives decrements, timer loads WAIT_FRAMES, next state is NEWBALL.
REQ-020 PLAY, miss with lives==1: lives goes to 0, timer loads WAIT_FRAMES, next state is OVER.
REQ-021 If hit and miss occur in the same cycle, miss SHALL take priority and the score is not incremented.
REQ-022 NEWBALL: graph_still=1; the timer decrements once per frame_tick; when timer==0 -> PLAY with a ball_reset pulse.
REQ-023 OVER: graph_still=1, game_over=1; the score is held for display; the timer decrements per frame_tick; when timer==0 -> IDLE.
REQ-024 hit and miss SHALL be ignored in IDLE, NEWBALL and OVER; start_edge SHALL be ignored outside IDLE.
REQ-025 Timer load SHALL take priority over a coincident frame_tick; the timer SHALL never decrement below 0.
REQ-026 ball_reset SHALL be asserted for exactly one clk cycle, registered, in the cycle after the transition into PLAY.
REQ-027 All outputs SHALL be registered or decoded directly from state registers, with no combinational path from inputs to outputs.

Reset
REQ-028 While reset=0: state=IDLE, score 00, lives=LIVES, timer=0, start-edge register=0, ball_reset=0, graph_still=1, game_over=0.
REQ-029 Reset asserted mid-game SHALL abort immediately to IDLE values; the first start_edge after release SHALL begin a new game.

Structure
REQ-030 Shared package pong_pkg SHALL hold the state enum, default LIVES and WAIT_FRAMES, and the BCD digit type.
REQ-031 A sub-module bcd_counter2 (two-digit BCD counter with clear and increment-enable, wrapping 99->00) SHALL hold the score.

Verification
REQ-032 Reset, then a start_edge -> state=PLAY, score 00, lives=3, ball_reset high for exactly 1 cycle, graph_still=0.
REQ-033 In PLAY, 10 hit pulses -> score_d1=1, score_d0=0; 100 hits total -> score 00.
REQ-034 A miss with lives=3 -> NEWBALL, lives=2; 119 frame_ticks leave the state at NEWBALL; the 120th frame_tick -> PLAY plus a ball_reset pulse.
REQ-035 hit and miss in the same cycle with score 05 and lives=1 -> score stays 05, lives=0, OVER, game_over=1; 120 frame_ticks -> IDLE.
REQ-036 btn_start held high for 1000 cycles in IDLE -> exactly one transition; a second start_edge during PLAY -> no effect.
REQ-037 reset pulled low mid-NEWBALL with the timer at 50 -> all outputs take their REQ-028 values within the same cycle, independent of clk.
